dcache_event_monitor: RTL and testbench

DCACHE_EVENT_MONITOR -- requirements
Module: dcache_event_monitor

---
 rtl/dcache_event_monitor_pkg.sv | 17 +
 rtl/miss_log_fifo.sv | 62 ++++++
 rtl/dcache_event_monitor.sv | 98 +++++++++
 tb/tb_dcache_event_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_event_monitor_pkg.sv
// dcache_event_monitor_pkg: shared FSM state, miss-log entry layout and default sizes.
package dcache_event_monitor_pkg;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_CNT_W     = 32;
    localparam int DEF_LOG_DEPTH = 4;

    typedef enum logic {
        IDLE      = 1'b0,
        MISS_PEND = 1'b1
    } mon_state_e;

    typedef struct packed {
        logic                  is_wr;
        logic                  wb;
        logic [DEF_ADDR_W-1:0] addr;
    } log_entry_t;
endpackage

// File: rtl/miss_log_fifo.sv
// miss_log_fifo: show-ahead FIFO of miss entries with a sticky flag for dropped pushes.
module miss_log_fifo #(
    parameter int DATA_W = 34,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              overflow_o
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;
    logic                r_overflow;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    // a full log still accepts a push when the head leaves in the same cycle
    always_comb begin
        w_empty = r_count == '0;
        w_full  = r_count == CNT_BITS'(DEPTH);
        w_pop   = pop_i && !w_empty && !clear_i;
        w_push  = push_i && !clear_i && (!w_full || w_pop);
        data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    end

    assign empty_o    = w_empty;
    assign overflow_o = r_overflow;

    always_ff @(posedge clk_i)
        if (w_push) r_mem[r_wr_ptr] <= data_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_BITS'(w_push) - CNT_BITS'(w_pop);
            if (push_i && !w_push) r_overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/dcache_event_monitor.sv
// dcache_event_monitor: counts dcache hit/miss/write-back/stall events and logs each miss.
module dcache_event_monitor
    import dcache_event_monitor_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    input  logic              cpu_stall_i,
    input  logic              ctrl_idle_i,
    input  logic              sram_dirty_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [CNT_W-1:0]  rd_hit_cnt_o,
    output logic [CNT_W-1:0]  rd_miss_cnt_o,
    output logic [CNT_W-1:0]  wr_hit_cnt_o,
    output logic [CNT_W-1:0]  wr_miss_cnt_o,
    output logic [CNT_W-1:0]  wb_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              log_valid_o,
    input  logic              log_rd_i,
    output logic              log_is_wr_o,
    output logic              log_wb_o,
    output logic [ADDR_W-1:0] log_addr_o,
    output logic              log_overflow_o
);
    localparam int N_CNT = 6;

    mon_state_e        r_state;
    mon_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt [N_CNT];
    logic [N_CNT-1:0]  w_inc;
    logic              w_idle;
    logic              w_miss;
    logic              w_rec;
    logic              w_push;
    logic              w_empty;
    logic [ADDR_W+1:0] w_head;

    // counter order: rd_hit, rd_miss, wr_hit, wr_miss, wb, stall
    always_comb begin
        w_idle      = r_state == IDLE;
        w_miss      = w_idle && cpu_stall_i && ctrl_idle_i;
        w_rec       = w_miss && (cpu_MemWrite_i || cpu_MemRead_i);
        w_inc[0]    = w_idle && !cpu_stall_i && !cpu_MemWrite_i && cpu_MemRead_i;
        w_inc[1]    = w_miss && !cpu_MemWrite_i && cpu_MemRead_i;
        w_inc[2]    = w_idle && !cpu_stall_i && cpu_MemWrite_i;
        w_inc[3]    = w_miss && cpu_MemWrite_i;
        w_inc[4]    = w_rec && sram_dirty_i;
        w_inc[5]    = cpu_stall_i;
        w_state_nxt = w_idle ? (w_miss ? MISS_PEND : IDLE) : (cpu_stall_i ? MISS_PEND : IDLE);
        w_push      = enable_i && w_rec;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= clear_i ? IDLE : w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < N_CNT; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < N_CNT; k++)
                if (clear_i) r_cnt[k] <= '0;
                else if (enable_i && w_inc[k] && !(&r_cnt[k])) r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
    end

    miss_log_fifo #(
        .DATA_W(ADDR_W + 2),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .push_i    (w_push),
        .pop_i     (log_rd_i),
        .data_i    ({cpu_MemWrite_i, sram_dirty_i, cpu_addr_i}),
        .data_o    (w_head),
        .empty_o   (w_empty),
        .overflow_o(log_overflow_o)
    );

    assign rd_hit_cnt_o  = r_cnt[0];
    assign rd_miss_cnt_o = r_cnt[1];
    assign wr_hit_cnt_o  = r_cnt[2];
    assign wr_miss_cnt_o = r_cnt[3];
    assign wb_cnt_o      = r_cnt[4];
    assign stall_cnt_o   = r_cnt[5];
    assign log_valid_o   = !w_empty;
    assign {log_is_wr_o, log_wb_o, log_addr_o} = w_head;
endmodule

// File: tb/tb_dcache_event_monitor.sv
// tb_dcache_event_monitor: table-driven counter checks plus a log scoreboard for miss sequences.
module tb_dcache_event_monitor;
    import dcache_event_monitor_pkg::*;

    typedef struct {
        int rd, wr, st, ci, en, cl, a;
        int rh, rm, wh, wm, wbc, sc;
    } row_t;

    logic        clk_i = 0, rst_i = 0, enable_i = 1, clear_i = 0;
    logic        rd = 0, wr = 0, st = 0, ci = 0, dirty = 0, log_rd = 0;
    logic [31:0] addr = 0;
    logic [31:0] c_rh, c_rm, c_wh, c_wm, c_wb, c_st, laddr;
    logic        valid, is_wr, wb, ovf;
    logic [3:0]  s_rh, s_rm, s_wh, s_wm, s_wb, s_st;
    logic [31:0] laddr4;
    logic        valid4, is_wr4, wb4, ovf4;

    int         n_cmp = 0, n_err = 0;
    row_t       rows [11];
    row_t       row_q [$];
    log_entry_t exp_log [$];

    dcache_event_monitor dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
        .cpu_MemRead_i(rd), .cpu_MemWrite_i(wr), .cpu_stall_i(st), .ctrl_idle_i(ci),
        .sram_dirty_i(dirty), .cpu_addr_i(addr),
        .rd_hit_cnt_o(c_rh), .rd_miss_cnt_o(c_rm), .wr_hit_cnt_o(c_wh), .wr_miss_cnt_o(c_wm),
        .wb_cnt_o(c_wb), .stall_cnt_o(c_st), .log_valid_o(valid), .log_rd_i(log_rd),
        .log_is_wr_o(is_wr), .log_wb_o(wb), .log_addr_o(laddr), .log_overflow_o(ovf)
    );

    dcache_event_monitor #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
        .cpu_MemRead_i(rd), .cpu_MemWrite_i(wr), .cpu_stall_i(st), .ctrl_idle_i(ci),
        .sram_dirty_i(dirty), .cpu_addr_i(addr),
        .rd_hit_cnt_o(s_rh), .rd_miss_cnt_o(s_rm), .wr_hit_cnt_o(s_wh), .wr_miss_cnt_o(s_wm),
        .wb_cnt_o(s_wb), .stall_cnt_o(s_st), .log_valid_o(valid4), .log_rd_i(log_rd),
        .log_is_wr_o(is_wr4), .log_wb_o(wb4), .log_addr_o(laddr4), .log_overflow_o(ovf4)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic chk_cnt(input string n, input int rh, rm, wh, wm, wbc, sc);
        check({n, "_rd_hit"}, c_rh, rh);
        check({n, "_rd_miss"}, c_rm, rm);
        check({n, "_wr_hit"}, c_wh, wh);
        check({n, "_wr_miss"}, c_wm, wm);
        check({n, "_wb"}, c_wb, wbc);
        check({n, "_stall"}, c_st, sc);
    endtask

    task automatic do_clear;
        clear_i = 1;
        cyc();
        clear_i = 0;
        exp_log.delete();
    endtask

    // one miss cycle (optionally popping in the same cycle) followed by the stall-release cycle
    task automatic miss(input logic w, input logic d, input logic [31:0] a, input logic p);
        wr = w; rd = !w; st = 1; ci = 1; dirty = d; addr = a; log_rd = p;
        cyc();
        wr = 0; rd = 0; st = 0; ci = 0; dirty = 0; log_rd = 0;
        cyc();
    endtask

    task automatic pop_chk(input string n);
        log_entry_t e;
        if (exp_log.size() == 0) begin
            check({n, "_valid"}, valid, 0);
        end else begin
            e = exp_log.pop_front();
            check({n, "_valid"}, valid, 1);
            check({n, "_is_wr"}, is_wr, e.is_wr);
            check({n, "_wb"}, wb, e.wb);
            check({n, "_addr"}, laddr, e.addr);
            log_rd = 1;
            cyc();
            log_rd = 0;
        end
    endtask

    initial begin
        rows[0]  = '{1, 0, 0, 0, 1, 0, 'h04, 1, 0, 0, 0, 0, 0};
        rows[1]  = '{0, 1, 0, 0, 1, 0, 'h08, 1, 0, 1, 0, 0, 0};
        rows[2]  = '{1, 1, 0, 0, 1, 0, 'h0C, 1, 0, 2, 0, 0, 0};
        rows[3]  = '{1, 0, 1, 0, 1, 0, 'h10, 1, 0, 2, 0, 0, 1};
        rows[4]  = '{1, 0, 0, 0, 1, 0, 'h14, 2, 0, 2, 0, 0, 1};
        rows[5]  = '{1, 0, 0, 0, 0, 0, 'h18, 2, 0, 2, 0, 0, 1};
        rows[6]  = '{1, 0, 1, 1, 0, 0, 'h1C, 2, 0, 2, 0, 0, 1};
        rows[7]  = '{1, 0, 0, 0, 1, 0, 'h20, 2, 0, 2, 0, 0, 1};
        rows[8]  = '{1, 0, 0, 0, 1, 0, 'h24, 3, 0, 2, 0, 0, 1};
        rows[9]  = '{1, 0, 1, 1, 1, 1, 'h28, 0, 0, 0, 0, 0, 0};
        rows[10] = '{1, 0, 0, 0, 1, 0, 'h2C, 1, 0, 0, 0, 0, 0};

        cyc();
        cyc();
        chk_cnt("reset", 0, 0, 0, 0, 0, 0);
        check("reset_valid", valid, 0);
        check("reset_ovf", ovf, 0);
        check("reset_is_wr", is_wr, 0);
        check("reset_wb", wb, 0);
        check("reset_addr", laddr, 0);
        check("reset_sat_rd_hit", s_rh, 0);
        rst_i = 1;

        // single-cycle rows: hits, priority, stall without idle, enable gating, clear
        for (int i = 0; i < 11; i++) begin
            row_t e;
            rd = rows[i].rd != 0; wr = rows[i].wr != 0; st = rows[i].st != 0;
            ci = rows[i].ci != 0; enable_i = rows[i].en != 0; clear_i = rows[i].cl != 0;
            addr = rows[i].a;
            row_q.push_back(rows[i]);
            cyc();
            e = row_q.pop_front();
            chk_cnt($sformatf("row%0d", i), e.rh, e.rm, e.wh, e.wm, e.wbc, e.sc);
            check($sformatf("row%0d_valid", i), valid, 0);
            check($sformatf("row%0d_ovf", i), ovf, 0);
        end
        rd = 0; wr = 0; st = 0; ci = 0; enable_i = 1; clear_i = 0;

        // read miss with a 12-cycle stall and a dirty victim
        do_clear();
        rd = 1; addr = 32'h200; st = 1; ci = 1; dirty = 1;
        cyc();
        exp_log.push_back('{1'b0, 1'b1, 32'h200});
        check("a_visible", valid, 1);
        ci = 0;
        repeat (11) cyc();
        st = 0;
        cyc();
        rd = 0; dirty = 0;
        chk_cnt("a", 0, 1, 0, 0, 1, 12);
        pop_chk("a_head");
        pop_chk("a_empty");

        // five write misses into a four-entry log
        do_clear();
        for (int i = 0; i < 5; i++) begin
            miss(1, 0, 32'(32'h1000 + i * 16), 0);
            if (i < 4) exp_log.push_back('{1'b1, 1'b0, 32'(32'h1000 + i * 16)});
        end
        chk_cnt("b", 0, 0, 0, 5, 0, 5);
        check("b_ovf", ovf, 1);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("b_pop%0d", i));
        pop_chk("b_empty");
        check("b_ovf_sticky", ovf, 1);

        // full log: push and pop in the same cycle
        do_clear();
        check("c_ovf_cleared", ovf, 0);
        for (int i = 0; i < 4; i++) begin
            miss(1, 0, 32'(32'h2000 + i * 16), 0);
            exp_log.push_back('{1'b1, 1'b0, 32'(32'h2000 + i * 16)});
        end
        check("c_head_before", laddr, 32'h2000);
        miss(1, 1, 32'h2040, 1);
        void'(exp_log.pop_front());
        exp_log.push_back('{1'b1, 1'b1, 32'h2040});
        check("c_ovf", ovf, 0);
        check("c_wr_miss", c_wm, 5);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("c_pop%0d", i));
        pop_chk("c_empty");

        // one entry: push and pop in the same cycle
        do_clear();
        miss(0, 0, 32'h3000, 0);
        exp_log.push_back('{1'b0, 1'b0, 32'h3000});
        miss(0, 0, 32'h3010, 1);
        void'(exp_log.pop_front());
        exp_log.push_back('{1'b0, 1'b0, 32'h3010});
        check("d_valid_kept", valid, 1);
        pop_chk("d_head");
        pop_chk("d_empty");

        // saturation on the 4-bit counter instance
        do_clear();
        rd = 1;
        repeat (14) cyc();
        check("sat_pre", s_rh, 4'hE);
        repeat (3) cyc();
        rd = 0;
        check("sat_hold", s_rh, 4'hF);
        check("sat_wide", c_rh, 17);

        // reset while a miss is pending
        do_clear();
        rd = 1; st = 1; ci = 1; addr = 32'h300;
        cyc();
        ci = 0;
        cyc();
        #2 rst_i = 0;
        #1;
        exp_log.delete();
        chk_cnt("rst_mid", 0, 0, 0, 0, 0, 0);
        check("rst_mid_valid", valid, 0);
        st = 0; rd = 1;
        @(posedge clk_i);
        #1 rst_i = 1;
        cyc();
        rd = 0;
        chk_cnt("rst_after", 1, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
